// File: rtl/sram_stream_fifo_pkg.sv
// sram_fifo_pkg
// Shared constants and helpers for the SRAM-backed stream FIFO.
//   FIFO_DATA_W / FIFO_DEPTH / FIFO_ADDR_W : default macro geometry (512 x 2)
//   FIFO_CNT_W                             : width of a 0..DEPTH occupancy count
//   OBUF_DEPTH / OBUF_CNT_W                : output buffer size and its counter width
//   obuf_idx_t / obuf_next()               : circular index type and wrap increment
package sram_fifo_pkg;

    localparam int FIFO_DATA_W = 2;
    localparam int FIFO_DEPTH  = 512;
    localparam int FIFO_ADDR_W = 9;
    localparam int FIFO_CNT_W  = FIFO_ADDR_W + 1;

    // Three slots cover the two-cycle issue-to-capture loop plus the word
    // currently being presented, which is what sustains one word per cycle.
    localparam int OBUF_DEPTH = 3;
    localparam int OBUF_CNT_W = 2;

    typedef logic [1:0] obuf_idx_t;

    // The buffer depth is not a power of two, so indices wrap explicitly.
    function automatic obuf_idx_t obuf_next(input obuf_idx_t idx);
        return (idx == obuf_idx_t'(OBUF_DEPTH - 1)) ? obuf_idx_t'(0) : idx + obuf_idx_t'(1);
    endfunction

endpackage

// File: rtl/sram_stream_fifo_if.sv
// sram_stream_fifo_if
// Valid/ready stream bundle used for both the producer and consumer sides.
//   valid : word present      (master -> slave)
//   data  : word              (master -> slave)
//   ready : word accepted     (slave -> master)
interface sram_stream_fifo_if
    import sram_fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/sram_stream_fifo_obuf.sv
// sram_fifo_obuf
// Three-entry circular buffer that receives words returning from the SRAM
// read port and presents the head to the consumer.
//   clock, reset : clock and asynchronous active-high reset
//   capture      : write cap_data into the tail this edge
//   cap_data     : word returning from the macro
//   pop          : consumer takes the head (ignored when empty)
//   valid        : buffer holds at least one word
//   head_data    : word at the head of the buffer
//   buf_cnt      : number of words held (0..3)
module sram_fifo_obuf
    import sram_fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  capture,
    input  logic [DATA_W-1:0]     cap_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_W-1:0]     head_data,
    output logic [OBUF_CNT_W-1:0] buf_cnt
);

    logic [DATA_W-1:0] slots [OBUF_DEPTH];
    obuf_idx_t         head;
    obuf_idx_t         tail;
    logic              take;

    assign valid     = (buf_cnt != '0);
    assign take      = pop & valid;
    assign head_data = slots[head];

    // The read-issue rule upstream guarantees a free slot (or a same-edge
    // pop) whenever capture is high, so the count cannot pass three.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                slots[i] <= '0;
            end
            head    <= '0;
            tail    <= '0;
            buf_cnt <= '0;
        end else begin
            if (capture) begin
                slots[tail] <= cap_data;
                tail        <= obuf_next(tail);
            end
            if (take) begin
                head <= obuf_next(head);
            end
            buf_cnt <= buf_cnt + OBUF_CNT_W'(capture) - OBUF_CNT_W'(take);
        end
    end

endmodule

// File: rtl/sram_stream_fifo.sv
// sram_stream_fifo
// Valid/ready stream FIFO built on a 1R1W SRAM macro with a one-cycle
// registered read, plus a small output buffer that hides the read latency.
//   clock, reset : single clock (also the macro CLKW/CLKR), async active-high reset
//   producer     : incoming stream (slave side)
//   consumer     : outgoing stream (master side)
//   count        : words held in SRAM + read in flight + output buffer
//   sram_web/aa/d: macro write port, active-low strobe
//   sram_reb/ab  : macro read port, active-low strobe
//   sram_q       : macro registered read data
module sram_stream_fifo
    import sram_fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic                clock,
    input  logic                reset,
    sram_stream_fifo_if.slave   producer,
    sram_stream_fifo_if.master  consumer,
    output logic [ADDR_W:0]     count,
    output logic                sram_web,
    output logic [ADDR_W-1:0]   sram_aa,
    output logic [DATA_W-1:0]   sram_d,
    output logic                sram_reb,
    output logic [ADDR_W-1:0]   sram_ab,
    input  logic [DATA_W-1:0]   sram_q
);

    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0]     wptr;
    logic [ADDR_W-1:0]     rptr;
    logic [CNT_W-1:0]      sram_cnt;
    logic                  rd_inflight;
    logic [OBUF_CNT_W-1:0] buf_cnt;
    logic                  accept;
    logic                  push;
    logic                  issue;
    logic                  buf_room;
    logic                  out_valid;
    logic [DATA_W-1:0]     out_data;

    // Occupancy and acceptance come from registers only, so a pop at full
    // frees a slot for the producer one cycle later, never combinationally.
    assign count  = sram_cnt + CNT_W'(rd_inflight) + CNT_W'(buf_cnt);
    assign accept = !reset && (count < CNT_W'(DEPTH));
    assign push   = producer.valid & accept;

    assign producer.ready = accept;

    assign sram_web = !push;
    assign sram_aa  = wptr;
    assign sram_d   = producer.data;

    // sram_cnt only includes writes committed at an earlier edge, so a read
    // can never target the address being written this same cycle. A pending
    // pop is not credited, keeping the buffer bound simple and safe.
    assign buf_room = ({1'b0, buf_cnt} + {2'b00, rd_inflight}) < 3'(OBUF_DEPTH);
    assign issue    = !reset && (sram_cnt != '0) && buf_room;

    assign sram_reb = !issue;
    assign sram_ab  = rptr;

    // Pointers wrap naturally because DEPTH is a power of two; sram_cnt
    // moves by the net of this cycle's write and read issue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            sram_cnt    <= '0;
            rd_inflight <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (issue) begin
                rptr <= rptr + ADDR_W'(1);
            end
            sram_cnt    <= sram_cnt + CNT_W'(push) - CNT_W'(issue);
            rd_inflight <= issue;
        end
    end

    // sram_q is only meaningful the cycle after a read strobe, which is
    // exactly when rd_inflight is set.
    sram_fifo_obuf #(
        .DATA_W    (DATA_W)
    ) u_obuf (
        .clock     (clock),
        .reset     (reset),
        .capture   (rd_inflight),
        .cap_data  (sram_q),
        .pop       (consumer.ready),
        .valid     (out_valid),
        .head_data (out_data),
        .buf_cnt   (buf_cnt)
    );

    assign consumer.valid = out_valid;
    assign consumer.data  = out_data;

endmodule

// File: tb/tb_sram_stream_fifo.sv
// tb_sram_stream_fifo
// Self-checking bench for sram_stream_fifo: behavioural SRAM macro model,
// scoreboard queue fed on every accepted push, and a monitor that compares
// every popped word and the reported occupancy against the queue.
module tb_sram_stream_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] count;
    logic       sram_web;
    logic [8:0] sram_aa;
    logic [1:0] sram_d;
    logic       sram_reb;
    logic [8:0] sram_ab;
    logic [1:0] sram_q = 2'b00;

    logic [1:0] exp_q [$];
    int         compared   = 0;
    int         mismatched = 0;
    bit         mon_en     = 1'b0;

    always #5 clock = ~clock;

    sram_stream_fifo_if #(.DATA_W(2)) producer_if ();
    sram_stream_fifo_if #(.DATA_W(2)) consumer_if ();

    sram_stream_fifo dut (
        .clock    (clock),
        .reset    (reset),
        .producer (producer_if),
        .consumer (consumer_if),
        .count    (count),
        .sram_web (sram_web),
        .sram_aa  (sram_aa),
        .sram_d   (sram_d),
        .sram_reb (sram_reb),
        .sram_ab  (sram_ab),
        .sram_q   (sram_q)
    );

    // Macro model: registered read, and random garbage on Q whenever no
    // read was strobed, so any capture without a pending read shows up.
    logic [1:0] mem [512];

    always @(posedge clock) begin
        if (!sram_web) mem[sram_aa] <= sram_d;
        if (!sram_reb) sram_q <= mem[sram_ab];
        else           sram_q <= 2'($urandom);
    end

    task automatic check_output(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [1:0] d, input logic r);
        producer_if.valid = v;
        producer_if.data  = d;
        consumer_if.ready = r;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: the FIFO holds exactly the words accepted and not
    // yet delivered, so count and in_ready follow from the queue length.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            check_output("count", int'(count), exp_q.size());
            check_output("in_ready", int'(producer_if.ready), int'(exp_q.size() < 512));
            if (consumer_if.valid && consumer_if.ready) begin
                if (exp_q.size() == 0) begin
                    check_output("spurious_out", 1, 0);
                end else begin
                    check_output("out_data", int'(consumer_if.data), int'(exp_q.pop_front()));
                end
            end
            if (producer_if.valid && producer_if.ready) exp_q.push_back(producer_if.data);
        end
    end

    task automatic drain_all(input string name);
        apply_stimulus(1'b0, 2'b00, 1'b1);
        for (int c = 0; c < 2000 && exp_q.size() != 0; c++) step();
        check_output(name, exp_q.size(), 0);
    endtask

    // Push until 'target' words are held, consumer stalled.
    task automatic fill_to(input int target, output int pushed);
        pushed = 0;
        for (int c = 0; c < 700 && pushed < target; c++) begin
            step();
            apply_stimulus(1'b1, 2'(pushed % 4), 1'b0);
            @(negedge clock);
            if (producer_if.ready) pushed++;
        end
    endtask

    initial begin
        int pushed;
        int valid_cycles;
        int max_count;

        apply_stimulus(1'b0, 2'b00, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_output("rst_web", int'(sram_web), 1);
        check_output("rst_reb", int'(sram_reb), 1);
        check_output("rst_in_ready", int'(producer_if.ready), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_output("post_rst_out_valid", int'(consumer_if.valid), 0);
        check_output("post_rst_out_data", int'(consumer_if.data), 0);
        check_output("post_rst_count", int'(count), 0);
        check_output("post_rst_in_ready", int'(producer_if.ready), 1);
        mon_en = 1'b1;

        // Single word latency from an empty FIFO.
        $display("[TB] single push latency");
        step(); apply_stimulus(1'b1, 2'b10, 1'b1);
        @(negedge clock);
        check_output("c0_web", int'(sram_web), 0);
        check_output("c0_aa", int'(sram_aa), 0);
        step(); apply_stimulus(1'b0, 2'b00, 1'b1);
        @(negedge clock);
        check_output("c1_reb", int'(sram_reb), 0);
        check_output("c1_ab", int'(sram_ab), 0);
        step(); @(negedge clock);
        check_output("c2_out_valid", int'(consumer_if.valid), 0);
        step(); @(negedge clock);
        check_output("c3_out_valid", int'(consumer_if.valid), 1);
        check_output("c3_out_data", int'(consumer_if.data), 2);
        step(); @(negedge clock);
        check_output("c4_count", int'(count), 0);

        // Fill to capacity, then pop at full while pushing.
        $display("[TB] fill to full");
        fill_to(512, pushed);
        check_output("fill_pushed", pushed, 512);
        step(); apply_stimulus(1'b1, 2'b11, 1'b1);
        @(negedge clock);
        check_output("full_in_ready", int'(producer_if.ready), 0);
        check_output("full_web", int'(sram_web), 1);
        check_output("full_count", int'(count), 512);
        step(); apply_stimulus(1'b1, 2'b01, 1'b0);
        @(negedge clock);
        check_output("after_pop_in_ready", int'(producer_if.ready), 1);
        check_output("after_pop_count", int'(count), 511);
        step(); apply_stimulus(1'b0, 2'b00, 1'b0);
        @(negedge clock);
        check_output("refill_count", int'(count), 512);

        // Drain must stream one word per cycle with no gaps.
        step(); apply_stimulus(1'b0, 2'b00, 1'b1);
        valid_cycles = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clock);
            if (consumer_if.valid) valid_cycles++;
            step();
        end
        check_output("drain_valid_cycles", valid_cycles, 512);
        @(negedge clock);
        check_output("drain_count", int'(count), 0);

        // Continuous streaming across the pointer wrap.
        $display("[TB] wrap-around stream");
        max_count = 0;
        for (int i = 0; i < 700; i++) begin
            step(); apply_stimulus(1'b1, 2'($urandom), 1'b1);
            @(negedge clock);
            if (int'(count) > max_count) max_count = int'(count);
        end
        check_output("wrap_max_count_le3", int'(max_count <= 3), 1);
        drain_all("wrap_drain");

        // Random traffic, balanced then producer-heavy.
        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            step(); apply_stimulus(1'($urandom), 2'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 1500; i++) begin
            step(); apply_stimulus(($urandom_range(0, 9) != 0), 2'($urandom), 1'($urandom));
        end
        drain_all("random_drain");

        // Reset with 200 words held and a read in flight.
        $display("[TB] reset mid-operation");
        fill_to(200, pushed);
        check_output("pre_rst_pushed", pushed, 200);
        step(); apply_stimulus(1'b1, 2'b00, 1'b1);
        step(); apply_stimulus(1'b0, 2'b00, 1'b0);
        @(negedge clock);
        check_output("pre_rst_issue", int'(sram_reb), 0);
        step();
        check_output("pre_rst_count", int'(count), 200);
        mon_en = 1'b0;
        exp_q.delete();
        apply_stimulus(1'b1, 2'b11, 1'b1);
        reset = 1'b1;
        #1;
        check_output("mid_rst_out_valid", int'(consumer_if.valid), 0);
        check_output("mid_rst_count", int'(count), 0);
        check_output("mid_rst_web", int'(sram_web), 1);
        check_output("mid_rst_reb", int'(sram_reb), 1);
        apply_stimulus(1'b0, 2'b00, 1'b0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        step(); apply_stimulus(1'b1, 2'b01, 1'b1);
        step(); apply_stimulus(1'b0, 2'b00, 1'b1);
        @(negedge clock);
        check_output("fresh_reb", int'(sram_reb), 0);
        check_output("fresh_ab", int'(sram_ab), 0);
        step(); @(negedge clock);
        check_output("fresh_t2_out_valid", int'(consumer_if.valid), 0);
        step(); @(negedge clock);
        check_output("fresh_t3_out_valid", int'(consumer_if.valid), 1);
        check_output("fresh_t3_out_data", int'(consumer_if.data), 1);
        drain_all("final_drain");
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sram_stream_fifo.md
Name: sram_stream_fifo

Overview:
Single-clock valid/ready stream FIFO controller wrapped around a 1R1W SRAM macro: 512 x 2-bit, active-low write and read strobes, registered read data with one-cycle latency.
- Drives the macro's write port (web/aa/d) and read port (reb/ab), and consumes its Q output.
- A 3-entry output buffer hides the macro read latency, giving full-throughput streaming.
- Sits between a producer stage and a consumer stage that need deep, cheap buffering.

Parameters:
DATA_W, 2, data width; equals the macro word width.
DEPTH, 512, macro word count; equals the total FIFO capacity.
ADDR_W, 9, macro address width, log2(DEPTH).

Ports:
clock  in  1  single clock for the whole block; also wired to the macro CLKW and CLKR.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  producer data valid.
in_ready  out  1  FIFO can accept a word.
in_data  in  DATA_W  producer data.
out_valid  out  1  output word valid.
out_ready  in  1  consumer accepts the word.
out_data  out  DATA_W  output word (head of FIFO).
count  out  ADDR_W+1  total words held (SRAM + in flight + output buffer).
sram_web  out  1  macro write enable, active low.
sram_aa  out  ADDR_W  macro write address.
sram_d  out  DATA_W  macro write data.
sram_reb  out  1  macro read enable, active low.
sram_ab  out  ADDR_W  macro read address.
sram_q  in  DATA_W  macro registered read data; garbage unless a read was issued in the previous cycle.

Behaviour:
- State: wptr and rptr (ADDR_W bits, wrap DEPTH-1 -> 0), sram_cnt (ADDR_W+1), rd_inflight (1 bit), 3-entry output buffer with buf_cnt (0..3).
- Reset values:
  - wptr, rptr, sram_cnt, rd_inflight, buf_cnt = 0.
  - out_valid = 0, out_data = 0, count = 0, in_ready = 1 after reset deasserts.
  - While reset is high: sram_web = 1, sram_reb = 1, in_ready = 0.
- push = in_valid & in_ready. in_ready = (count < DEPTH), derived from registers only.
- Write path (combinational):
  - sram_web = !push; sram_aa = wptr; sram_d = in_data.
  - On push: wptr += 1, sram_cnt += 1 at the same edge.
- Read issue:
  - issue = (sram_cnt != 0) & (buf_cnt + rd_inflight < 3); pop credit is not counted.
  - sram_reb = !issue; sram_ab = rptr.
  - On issue: rptr += 1, sram_cnt -= 1, rd_inflight <= 1. Otherwise rd_inflight <= 0.
- Read-after-write hazard: sram_cnt counts only writes committed at a previous edge, so the same-edge address collision cannot be issued.
- Capture: when rd_inflight = 1, sram_q is written into the output buffer tail at the edge. sram_q is ignored when rd_inflight = 0.
- Output: out_valid = (buf_cnt != 0); out_data = buffer head. pop = out_valid & out_ready.
- Simultaneous push, issue, capture and pop in one cycle are all legal. Counters update by net delta.
  - Capture into the buffer and pop from a full buffer in the same cycle is legal.
  - buf_cnt never exceeds 3.
- count = sram_cnt + rd_inflight + buf_cnt, never exceeds DEPTH.
- Latency: a word pushed in cycle t (empty FIFO, out_ready = 1):
  - read issued in t+1;
  - sram_q valid in t+2;
  - out_valid in t+3.
- Throughput: one word per cycle sustained in steady state.
- Full: count = DEPTH -> in_ready = 0, sram_web = 1. A pop in the same cycle does not raise in_ready until the next cycle.
- Empty: no read is issued and sram_reb stays 1.
- Reset mid-operation clears all pointers, counters and buffer state immediately. SRAM contents are not cleared and are treated as garbage.

Decomposition:
- Package sram_fifo_pkg holds OBUF_DEPTH = 3, the default DATA_W/DEPTH/ADDR_W, and a count-width helper constant.
- One sub-module, sram_fifo_obuf: the 3-entry circular output buffer with its capture/pop interface and buf_cnt.
- Pointer, issue and write logic stay in the top level.

Test Plan:
1. Reset then a single push of data 2'b10 in cycle 0 -> sram_web = 0 with aa = 0 in cycle 0; sram_reb = 0 with ab = 0 in cycle 1; out_valid = 1 with out_data = 2'b10 in cycle 3; count 1 -> 0 after the pop.
2. Fill with out_ready = 0, pushing values i%4 -> in_ready drops when count = 512; then drain with out_ready = 1 -> 512 words in order, one per cycle after the initial 3-cycle latency.
3. Wrap-around: 700 continuous push/pop words with out_ready = 1 -> wptr/rptr pass 511 -> 0, no loss or duplication, count steady at 3 or less.
4. Random out_ready backpressure (50%) with random in_valid -> output order matches the scoreboard, buf_cnt ≤ 3, and no capture ever occurs with rd_inflight = 0.
5. Simultaneous push and pop at count = DEPTH -> the push is refused that cycle, in_ready = 1 the next cycle, and count ends at 511 then 512.
6. Assert reset with count = 200 and rd_inflight = 1 -> out_valid = 0, count = 0, sram_web = sram_reb = 1 immediately; after release a fresh push returns its new data in cycle t+3.
